// File: rtl/program_loader.sv
// Program loader: encodes (rd, imm) pairs as addi rd,x0,imm and writes
// them to consecutive instruction-memory words, then raises done.
module program_loader #(
  parameter int size = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [11:0]     in_imm,
  input  logic            in_last,
  output logic            mem_write_enable,
  output logic [31:0]     mem_address,
  output logic [31:0]     mem_data_in,
  output logic [size:0]   word_count,
  output logic            done,
  output logic            overflow
);

  localparam logic [size:0] CAP = {1'b1, {size{1'b0}}};
  localparam logic [size:0] ONE = {{size{1'b0}}, 1'b1};

  typedef enum logic {LOAD, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [size:0]   r_count;
  logic [size-1:0] r_addr;
  logic [31:0]     r_data;
  logic            r_we;
  logic            r_ovf;
  logic            w_accept;
  logic            w_ovf_set;
  logic [size:0]   w_count_inc;
  logic [31:0]     w_enc;

  assign w_count_inc = r_count + ONE;
  assign w_enc = {in_imm, 8'h00, in_rd, 7'b0010011};

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    w_accept   = 1'b0;
    w_ovf_set  = 1'b0;
    unique case (r_state)
      LOAD: begin
        in_ready = (r_count < CAP);
        w_accept = in_valid && in_ready;
        if (w_accept && (in_last || w_count_inc == CAP))
          w_state_nx = DONE;
      end
      DONE: begin
        w_ovf_set = in_valid;
      end
      default: w_state_nx = LOAD;
    endcase
  end

  // reset also cancels a write strobe pending for the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_count <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_we    <= w_accept;
      if (w_accept) begin
        r_count <= w_count_inc;
        r_addr  <= r_count[size-1:0];
        r_data  <= w_enc;
      end
      if (w_ovf_set)
        r_ovf <= 1'b1;
    end
  end

  assign mem_write_enable = r_we;
  assign mem_address      = {{(32-size){1'b0}}, r_addr};
  assign mem_data_in      = r_data;
  assign word_count       = r_count;
  assign done             = (r_state == DONE);
  assign overflow         = r_ovf;

endmodule
